// File: rtl/add_handshake_checker.sv
// Drives a self-timed adder over a 4-phase req/fin handshake and checks each result
// against a clocked reference. Optional build macro: ADD_LATENCY_MEASURE_EN.
//
// state    | meaning
// IDLE     | waiting for req_in with synced fin low
// SETUP    | operands settling, reference computed
// REQ_HI   | add_req high, waiting for synced fin rise
// REQ_LO   | add_req low, waiting for synced fin fall
// FAULT    | fin stuck high; only rst leaves
module add_handshake_checker #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  input  logic             sub_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] s_out,
  output logic             cout_out,
  output logic             match,
  output logic             timeout,
  output logic             fault,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             add_req,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic             add_fin,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout
`ifdef ADD_LATENCY_MEASURE_EN
  ,
  output logic [15:0]      lat_last,
  output logic [15:0]      lat_max
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]    T_LOAD  = TW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_REQ_HI, S_REQ_LO, S_FAULT} state_t;

  state_t state, state_n;
  logic [SYNC_STAGES-1:0] fin_sync;
  logic                   fin_s;
  logic [TW-1:0]          tmr;
  logic [WIDTH:0]         ref_q;
  logic accept, start, capture, hi_to, finish, lo_to;

  // Left unreset so the synced level always reflects the real adder fin.
  always_ff @(posedge clk)
    fin_sync <= {fin_sync[SYNC_STAGES-2:0], add_fin};

  assign fin_s = fin_sync[SYNC_STAGES-1];
  assign busy  = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    start   = 1'b0;
    capture = 1'b0;
    hi_to   = 1'b0;
    finish  = 1'b0;
    lo_to   = 1'b0;
    case (state)
      S_IDLE:
        if (req_in && !fin_s) begin
          accept  = 1'b1;
          state_n = S_SETUP;
        end
      S_SETUP: begin
        start   = 1'b1;
        state_n = S_REQ_HI;
      end
      S_REQ_HI:
        if (fin_s) begin
          capture = 1'b1;
          state_n = S_REQ_LO;
        end else if (tmr == '0) begin
          hi_to   = 1'b1;
          state_n = S_REQ_LO;
        end
      S_REQ_LO:
        if (!fin_s) begin
          finish  = 1'b1;
          state_n = S_IDLE;
        end else if (tmr == '0) begin
          lo_to   = 1'b1;
          state_n = S_FAULT;
        end
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_IDLE;
    endcase
  end

  // Down-counter loaded on phase entry; terminal count gives exactly TIMEOUT cycles per phase.
  always_ff @(posedge clk) begin
    if (rst)
      tmr <= '0;
    else if (start || capture || hi_to)
      tmr <= T_LOAD;
    else if ((state == S_REQ_HI || state == S_REQ_LO) && tmr != '0)
      tmr <= tmr - TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      add_req  <= 1'b0;
      ref_q    <= '0;
      s_out    <= '0;
      cout_out <= 1'b0;
      match    <= 1'b0;
      timeout  <= 1'b0;
      fault    <= 1'b0;
      fin      <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      fin <= finish || lo_to;
      if (accept) begin
        add_a   <= a_in;
        add_b   <= sub_in ? ~b_in : b_in;
        add_cin <= sub_in;
      end
      if (start) begin
        add_req <= 1'b1;
        ref_q   <= {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(add_cin);
      end
      if (capture || hi_to)
        add_req <= 1'b0;
      if (capture) begin
        s_out    <= add_s;
        cout_out <= add_cout;
        match    <= ({add_cout, add_s} == ref_q);
        timeout  <= 1'b0;
      end
      if (hi_to) begin
        timeout <= 1'b1;
        match   <= 1'b0;
      end
      if (lo_to) begin
        fault <= 1'b1;
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
      end
      if (finish) begin
        if (match) begin
          if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef ADD_LATENCY_MEASURE_EN
  logic [15:0] lat_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt  <= '0;
      lat_last <= '0;
      lat_max  <= '0;
    end else begin
      if (start)
        lat_cnt <= '0;
      else if (state == S_REQ_HI && !fin_s && lat_cnt != 16'hFFFF)
        lat_cnt <= lat_cnt + 16'd1;
      if (capture) begin
        lat_last <= lat_cnt;
        if (lat_cnt > lat_max) lat_max <= lat_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_add_handshake_checker.sv
// Directed bench for add_handshake_checker with a behavioural self-timed adder model
// (programmable response delay, stuck-low, stuck-high and corrupted-sum modes).
module tb_add_handshake_checker;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int TMO   = 15;
  localparam int CW    = 2;

  logic             clk, rst, req_in, sub_in;
  logic [WIDTH-1:0] a_in, b_in;
  logic             busy, fin, cout_out, match, timeout, fault;
  logic [WIDTH-1:0] s_out;
  logic [CW-1:0]    pass_cnt, fail_cnt;
  logic             add_req, add_cin, add_fin, add_cout;
  logic [WIDTH-1:0] add_a, add_b, add_s;
`ifdef ADD_LATENCY_MEASURE_EN
  logic [15:0]      lat_last, lat_max;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int fin_cnt = 0;

  add_handshake_checker #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .sub_in(sub_in), .a_in(a_in), .b_in(b_in),
    .busy(busy), .fin(fin), .s_out(s_out), .cout_out(cout_out), .match(match),
    .timeout(timeout), .fault(fault), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .add_req(add_req), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_fin(add_fin), .add_s(add_s), .add_cout(add_cout)
`ifdef ADD_LATENCY_MEASURE_EN
    , .lat_last(lat_last), .lat_max(lat_max)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // adder model
  logic [3:0]       dly;
  logic             stuck_lo, stick_en, stuck_q, bad_en, fin_raw;
  logic [WIDTH-1:0] bad_val;
  logic [15:0]      req_pipe;
  logic [WIDTH:0]   sum_full;

  always @(posedge clk) req_pipe <= {req_pipe[14:0], add_req};
  always @(posedge clk) begin
    if (!stick_en)    stuck_q <= 1'b0;
    else if (fin_raw) stuck_q <= 1'b1;
  end
  assign fin_raw  = (dly == 4'd0) ? add_req : req_pipe[dly - 4'd1];
  assign add_fin  = !stuck_lo && (fin_raw || stuck_q);
  assign sum_full = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+1)'(add_cin);
  assign add_s    = bad_en ? bad_val : sum_full[WIDTH-1:0];
  assign add_cout = sum_full[WIDTH];

  always @(negedge clk) if (fin === 1'b1) fin_cnt <= fin_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    req_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // One operation: lat = cycles from the accepting edge to the fin edge.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub,
                       output int lat, output int hi_cyc,
                       output logic [WIDTH-1:0] b_seen, output logic cin_seen);
    @(negedge clk);
    a_in = a; b_in = b; sub_in = sub; req_in = 1'b1;
    lat = -1; hi_cyc = 0; b_seen = '0; cin_seen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        req_in   = 1'b0;
        b_seen   = add_b;
        cin_seen = add_cin;
      end
      if (add_req) hi_cyc++;
      if (fin) begin
        lat = i - 1;
        break;
      end
    end
    chk("op_fin_seen", 64'(lat >= 0), 64'd1);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int lat, hi_cyc, f0, nfin, last_fin, min_sp;
  logic [WIDTH-1:0] b_seen;
  logic cin_seen;

  initial begin
    rst = 1'b1; req_in = 1'b0; sub_in = 1'b0; a_in = '0; b_in = '0;
    dly = 4'd0; stuck_lo = 1'b0; stick_en = 1'b0; bad_en = 1'b0; bad_val = '0;
    do_reset();
    #1;
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_fin",   64'(fin), 64'd0);
    chk("rst_s",     64'(s_out), 64'd0);
    chk("rst_match", 64'(match), 64'd0);
    chk("rst_pass",  64'(pass_cnt), 64'd0);
    chk("rst_fail",  64'(fail_cnt), 64'd0);
    chk("rst_req",   64'(add_req), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);

    // reset in the middle of REQ_HI drops add_req at once
    stuck_lo = 1'b1;
    @(negedge clk);
    a_in = 32'd9; b_in = 32'd9; sub_in = 1'b0; req_in = 1'b1;
    @(posedge clk); #1 req_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("midrst_req_before", 64'(add_req), 64'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_req_after", 64'(add_req), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b0;
    stuck_lo = 1'b0;
    repeat (4) @(negedge clk);

    // add with carry out, adder responds after 5 cycles
    dly = 4'd5;
    f0 = fin_cnt;
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, lat, hi_cyc, b_seen, cin_seen);
    chk("add_s",    64'(s_out), 64'd0);
    chk("add_cout", 64'(cout_out), 64'd1);
    chk("add_match", 64'(match), 64'd1);
    chk("add_pass", 64'(pass_cnt), 64'd1);
    chk("add_fail", 64'(fail_cnt), 64'd0);
    chk("add_busy_at_fin", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("fin_width", 64'(fin), 64'd0);
    chk("fin_count", 64'(fin_cnt - f0), 64'd1);

    // subtract 5-7, instant adder, minimum latency
    dly = 4'd0;
    do_op(32'd5, 32'd7, 1'b1, lat, hi_cyc, b_seen, cin_seen);
    chk("sub_add_b",  64'(b_seen), 64'hFFFF_FFF8);
    chk("sub_cin",    64'(cin_seen), 64'd1);
    chk("sub_s",      64'(s_out), 64'hFFFF_FFFE);
    chk("sub_cout",   64'(cout_out), 64'd0);
    chk("sub_match",  64'(match), 64'd1);
    chk("sub_latency", 64'(lat), 64'(3 + 2*SYNC));
    chk("sub_pass",   64'(pass_cnt), 64'd2);

    // corrupted sum
    dly = 4'd2; bad_en = 1'b1; bad_val = 32'd4;
    do_op(32'd1, 32'd2, 1'b0, lat, hi_cyc, b_seen, cin_seen);
    bad_en = 1'b0;
    chk("mis_s",     64'(s_out), 64'd4);
    chk("mis_match", 64'(match), 64'd0);
    chk("mis_fail",  64'(fail_cnt), 64'd1);
    chk("mis_pass",  64'(pass_cnt), 64'd2);

    // phase-1 timeout: fin never rises
    stuck_lo = 1'b1;
    do_op(32'd8, 32'd8, 1'b0, lat, hi_cyc, b_seen, cin_seen);
    stuck_lo = 1'b0;
    chk("to_req_cycles", 64'(hi_cyc), 64'(TMO));
    chk("to_timeout", 64'(timeout), 64'd1);
    chk("to_match",   64'(match), 64'd0);
    chk("to_fail",    64'(fail_cnt), 64'd2);
    chk("to_s_held",  64'(s_out), 64'd4);
    chk("to_busy",    64'(busy), 64'd0);

    // normal op after a timeout clears timeout
    dly = 4'd1;
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat, hi_cyc, b_seen, cin_seen);
    chk("post_to_s",       64'(s_out), 64'h2345_6789);
    chk("post_to_timeout", 64'(timeout), 64'd0);
    chk("post_to_match",   64'(match), 64'd1);
    chk("post_to_pass",    64'(pass_cnt), 64'd3);

    // back-to-back with req_in held high, pass_cnt saturates at 3
    do_reset();
    #1 chk("b2b_rst_pass", 64'(pass_cnt), 64'd0);
    dly = 4'd0;
    @(negedge clk);
    a_in = 32'd10; b_in = 32'd20; sub_in = 1'b0; req_in = 1'b1;
    nfin = 0; last_fin = -1; min_sp = 1000;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (fin) begin
        if (last_fin >= 0 && (i - last_fin) < min_sp) min_sp = i - last_fin;
        last_fin = i;
        nfin++;
        if (nfin == 5) begin
          req_in = 1'b0;
          break;
        end
      end
    end
    chk("b2b_ops",     64'(nfin), 64'd5);
    chk("b2b_spacing", 64'(min_sp >= 3 + 2*SYNC), 64'd1);
    chk("b2b_pass",    64'(pass_cnt), 64'd3);
    chk("b2b_fail",    64'(fail_cnt), 64'd0);
    chk("b2b_s",       64'(s_out), 64'd30);

    // phase-2 fault: fin sticks high
    repeat (3) @(negedge clk);
    stick_en = 1'b1;
    do_op(32'd3, 32'd4, 1'b0, lat, hi_cyc, b_seen, cin_seen);
    chk("flt_fault", 64'(fault), 64'd1);
    chk("flt_busy",  64'(busy), 64'd1);
    chk("flt_fail",  64'(fail_cnt), 64'd1);
    chk("flt_s",     64'(s_out), 64'd7);
    @(negedge clk); #1;
    f0 = fin_cnt;
    req_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("flt_absorb_busy", 64'(busy), 64'd1);
    chk("flt_absorb_fail", 64'(fail_cnt), 64'd1);
    chk("flt_absorb_req",  64'(add_req), 64'd0);
    chk("flt_absorb_fins", 64'(fin_cnt - f0), 64'd0);

    // reset clears fault; IDLE refuses while the adder fin is still high
    do_reset();
    #1;
    chk("flt_rst_fault", 64'(fault), 64'd0);
    chk("flt_rst_busy",  64'(busy), 64'd0);
    req_in = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_blocks_fin_high", 64'(busy), 64'd0);
    stick_en = 1'b0;
    nfin = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin
        nfin = 1;
        break;
      end
    end
    req_in = 1'b0;
    chk("accept_after_fin_low", 64'(nfin), 64'd1);
    nfin = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (fin) begin
        nfin = 1;
        break;
      end
    end
    chk("recover_fin",   64'(nfin), 64'd1);
    chk("recover_match", 64'(match), 64'd1);
    chk("recover_pass",  64'(pass_cnt), 64'd1);
    chk("recover_s",     64'(s_out), 64'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
